// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX/MEM pipeline register with valid/ready handshake and one-entry skid buffer
//   clock, reset              rising-edge clock, synchronous active-high reset (wins over flush)
//   flush                     synchronous flush: empties both slots, drops any same-cycle input
//   in_valid/in_ready         EX-side handshake; in_ready depends on registered state only
//   in_pc..in_ctrl            EX bundle (pc, alu, rd1, rd2, zero, wreg, ctrl)
//   out_valid/out_ready       MEM-side handshake
//   out_pc..out_ctrl          main-slot bundle, forced to zero while out_valid is low
//   fwd_valid/reg/data        hazard-unit forwarding tap, taken from the main slot only
//   stall_cnt                 saturating count of cycles with out_valid & !out_ready
module ex_mem_skid_stage #(
    parameter int DATA_W       = 64,
    parameter int REG_W        = 5,
    parameter int CTRL_W       = 8,
    parameter int REGWRITE_BIT = 7,
    parameter int ZERO_REG     = 31,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic              in_zero,
    input  logic [REG_W-1:0]  in_wreg,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic              out_zero,
    output logic [REG_W-1:0]  out_wreg,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int BW = 4 * DATA_W + 1 + REG_W + CTRL_W;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    main_q, main_d, skid_q, skid_d;
    logic [BW-1:0]    in_bus, out_bus;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign in_bus    = {in_pc, in_alu, in_rd1, in_rd2, in_zero, in_wreg, in_ctrl};
    assign in_ready  = (state_q != SKID) & ~reset;
    // Gating with reset keeps every output at zero in the reset cycle itself,
    // even when the registers still hold pre-reset contents.
    assign out_valid = (state_q != EMPTY) & ~reset;
    // Bubble gating: an empty stage never shows stale control bits downstream.
    assign out_bus   = out_valid ? main_q : '0;
    assign {out_pc, out_alu, out_rd1, out_rd2, out_zero, out_wreg, out_ctrl} = out_bus;

    assign fwd_reg   = out_wreg;
    assign fwd_data  = out_alu;
    assign fwd_valid = out_valid & out_ctrl[REGWRITE_BIT] & (out_wreg != REG_W'(ZERO_REG));

    assign stall_cnt = reset ? '0 : cnt_q;
    assign cnt_d     = (out_valid & ~out_ready & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;

    // In EMPTY and FULL in_ready is high outside reset, so in_valid alone
    // means an input transfer here.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_d  = in_bus;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (in_valid & out_ready) begin
                    main_d = in_bus;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else if (in_valid) begin
                    skid_d  = in_bus;
                    state_d = SKID;
                end
            end
            SKID: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: queue-based scoreboard bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;
    localparam int NW  = 4;
    localparam int SAT = 15;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        zero;
        logic [4:0]  wreg;
        logic [7:0]  ctrl;
    } bundle_t;

    logic          clock = 1'b1;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0]   in_pc, in_alu, in_rd1, in_rd2, out_pc, out_alu, out_rd1, out_rd2, fwd_data;
    logic          in_zero, out_zero, fwd_valid;
    logic [4:0]    in_wreg, out_wreg, fwd_reg;
    logic [7:0]    in_ctrl, out_ctrl;
    logic [NW-1:0] stall_cnt;

    ex_mem_skid_stage #(.CNT_W(NW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu(in_alu), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_zero(in_zero), .in_wreg(in_wreg), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu(out_alu), .out_rd1(out_rd1), .out_rd2(out_rd2),
        .out_zero(out_zero), .out_wreg(out_wreg), .out_ctrl(out_ctrl),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    bundle_t q[$];
    bundle_t exp_b, cur_in;
    int      cnt_m = 0;
    int      checks = 0;
    int      fails = 0;
    bit      exp_v, in_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: the stage is an ordered queue of at most two accepted bundles;
    // the head is what MEM sees. Compare first, then apply this cycle's edge.
    always @(negedge clock) begin
        exp_v = !reset && q.size() > 0;
        exp_b = exp_v ? q[0] : '0;
        chk("in_ready", in_ready, !reset && q.size() < 2);
        chk("out_valid", out_valid, exp_v);
        chk("out_pc", out_pc, exp_b.pc);
        chk("out_alu", out_alu, exp_b.alu);
        chk("out_rd1", out_rd1, exp_b.rd1);
        chk("out_rd2", out_rd2, exp_b.rd2);
        chk("out_zero", out_zero, exp_b.zero);
        chk("out_wreg", out_wreg, exp_b.wreg);
        chk("out_ctrl", out_ctrl, exp_b.ctrl);
        chk("fwd_valid", fwd_valid, exp_v && exp_b.ctrl[7] && exp_b.wreg != 5'd31);
        chk("fwd_reg", fwd_reg, exp_b.wreg);
        chk("fwd_data", fwd_data, exp_b.alu);
        chk("stall_cnt", stall_cnt, reset ? 0 : cnt_m);
        cur_in = {in_pc, in_alu, in_rd1, in_rd2, in_zero, in_wreg, in_ctrl};
        in_acc = in_valid && q.size() < 2;
        if (reset) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (exp_v && !out_ready && cnt_m < SAT) cnt_m++;
            if (exp_v && out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_acc) q.push_back(cur_in);
        end
    end

    task automatic drive(input bit iv, input bit ordy, input bit fl, input bit rs,
                         input logic [63:0] alu, input logic [4:0] wreg, input logic [7:0] ctrl);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        in_alu    = alu;
        in_wreg   = wreg;
        in_ctrl   = ctrl;
        in_pc     = {$urandom, $urandom};
        in_rd1    = {$urandom, $urandom};
        in_rd2    = {$urandom, $urandom};
        in_zero   = 1'($urandom);
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) drive(1, 1, 0, 0, 64'(i), 5'd1, 8'h86);
        repeat (2) drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 64'd10, 5'd2, 8'h82);
        drive(1, 0, 0, 0, 64'd11, 5'd2, 8'h82);
        repeat (3) drive(1, 0, 0, 0, 64'd12, 5'd2, 8'h82);
        drive(1, 1, 0, 0, 64'd12, 5'd2, 8'h82);
        drive(1, 1, 0, 0, 64'd12, 5'd2, 8'h82);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 64'd20, 5'd4, 8'h88);
        drive(1, 0, 0, 0, 64'd21, 5'd4, 8'h88);
        drive(1, 0, 1, 0, 64'd22, 5'd4, 8'h88);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 64'hDEAD, 5'd3, 8'h80);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 64'hDEAD, 5'd31, 8'h80);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 64'hDEAD, 5'd3, 8'h00);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 64'd30, 5'd5, 8'h80);
        repeat (20) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 64'd40, 5'd6, 8'h80);
        drive(1, 0, 0, 0, 64'd41, 5'd6, 8'h80);
        drive(1, 0, 1, 1, 64'd42, 5'd6, 8'h80);
        repeat (2) drive(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 199) == 0, {$urandom, $urandom},
                  5'($urandom_range(0, 3) == 0 ? 31 : $urandom), 8'($urandom));
        drive(0, 1, 0, 0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
